// File: rtl/shift_rows_pipe_if.sv
// Stream bundle for the ShiftRows engine: upstream beat, downstream beat and fill level.
// The slave modport is the engine's view; master is the surrounding datapath's view.
interface shift_rows_pipe_if #(
    parameter int NB = 4
) ();
    localparam int W = 32 * NB;

    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_inv;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_inv, out_data, occupancy
    );

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_inv, out_data, occupancy
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows for Nb = 4, 6, 8 with a main + skid register pair.
// The permutation is wiring on the input side; out_* always come straight from the main register.
module shift_rows_pipe #(
    parameter int NB = 4,
    parameter int W  = 32 * NB
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_rows_pipe_if.slave     bus_io
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (W != 32 * NB) begin : g_bad_w
        $error("shift_rows_pipe: W must equal 32*NB");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         main_inv_q, main_inv_d;
    logic         skid_inv_q, skid_inv_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] perm_data;
    logic         in_xfer;
    logic         out_xfer;

    // Byte 4c+r (MSB byte first) is row r, column c; Nb=8 uses row offsets 0,1,3,4.
    for (genvar gi = 0; gi < NB; gi++) begin : g_col
        for (genvar gj = 0; gj < 4; gj++) begin : g_row
            localparam int S   = (NB == 8 && gj >= 2) ? gj + 1 : gj;
            localparam int FWD = (gi + S) % NB;
            localparam int INV = (gi + NB - S) % NB;
            localparam int DST = 4 * gi + gj;
            assign perm_data[W-1-8*DST -: 8] = bus_io.in_inv
                ? bus_io.in_data[W-1-8*(4*INV+gj) -: 8]
                : bus_io.in_data[W-1-8*(4*FWD+gj) -: 8];
        end
    end

    assign in_xfer  = bus_io.in_valid & in_ready_q;
    assign out_xfer = (state_q != EMPTY) & bus_io.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_inv_d  = main_inv_q;
        skid_data_d = skid_data_q;
        skid_inv_d  = skid_inv_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d     = ONE;
                    main_data_d = perm_data;
                    main_inv_d  = bus_io.in_inv;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = perm_data;
                    main_inv_d  = bus_io.in_inv;
                end else if (in_xfer) begin
                    state_d     = FULL;
                    skid_data_d = perm_data;
                    skid_inv_d  = bus_io.in_inv;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain case exists
                if (out_xfer) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_inv_d  = skid_inv_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_inv_q  <= 1'b0;
            skid_data_q <= '0;
            skid_inv_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_inv_q  <= main_inv_d;
            skid_data_q <= skid_data_d;
            skid_inv_q  <= skid_inv_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = (state_q != EMPTY);
    assign bus_io.out_data  = main_data_q;
    assign bus_io.out_inv   = main_inv_q;
    assign bus_io.occupancy = state_q;

endmodule
